// File: rtl/proc_n_if.sv
// -----------------------------------------------------------------------------
// proc_n_if
// Handshake and bus bundle between proc_n and the instruction/data source
// (ROM or switches) plus whatever observes the shared bus.
//
//   Run       source -> proc  start request, sampled by the processor in T0
//   DIN       source -> proc  instruction word in T0, immediate in T1 (mvi)
//   Done      proc -> source  high in the final step of every instruction
//   BusWires  proc -> source  shared bus value, 0 when nothing drives it
//   Zero      proc -> source  registered flag, 1 when G == 0
//
// master : the instruction source / observer side
// slave  : the processor side
// -----------------------------------------------------------------------------
interface proc_n_if #(
  parameter int N = 16
);
  logic         Run;
  logic [N-1:0] DIN;
  logic         Done;
  logic [N-1:0] BusWires;
  logic         Zero;

  modport master (
    output Run,
    output DIN,
    input  Done,
    input  BusWires,
    input  Zero
  );

  modport slave (
    input  Run,
    input  DIN,
    output Done,
    output BusWires,
    output Zero
  );
endinterface

// File: rtl/proc_n.sv
// -----------------------------------------------------------------------------
// proc_n
// Parametrised 8-register processor built around a single shared bus.
// A 9-bit instruction {I[2:0], X[2:0], Y[2:0]} is fetched from DIN[8:0] in
// step T0 when Run is high; mv/mvi/mvnz/reserved complete in T1, add/sub/and
// walk T1 (A <= Rx), T2 (G <= A op Ry, Zero updated) and T3 (Rx <= G).
//
// Parameters
//   N        data / bus width, must be >= 9 because IR is taken from DIN[8:0]
//
// Ports
//   Clock    in   rising-edge clock
//   Resetn   in   synchronous active-low reset; clears every register,
//                 sets Zero and forces Done/BusWires low while asserted
//   bus      slave modport of proc_n_if (Run, DIN, Done, BusWires, Zero)
// -----------------------------------------------------------------------------
module proc_n #(
  parameter int N = 16
) (
  input  logic     Clock,
  input  logic     Resetn,
  proc_n_if.slave  bus
);

  // ---------------------------------------------------------------------------
  // Types
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_e;

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_MVNZ = 3'b101,
    OP_RSV6 = 3'b110,
    OP_RSV7 = 3'b111
  } op_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  step_e        step_q, step_d;
  logic [8:0]   ir_q,   ir_d;
  logic [N-1:0] a_q,    a_d;
  logic [N-1:0] g_q,    g_d;
  logic         zero_q, zero_d;
  logic [N-1:0] r_q [8];
  logic [N-1:0] r_d [8];

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  op_e          op;
  logic [2:0]   rx_sel;
  logic [2:0]   ry_sel;
  logic         is_alu;
  logic [N-1:0] rx_val;
  logic [N-1:0] ry_val;
  logic [N-1:0] bus_val;
  logic [N-1:0] alu_res;
  logic         done_raw;

  assign op     = op_e'(ir_q[8:6]);
  assign rx_sel = ir_q[5:3];
  assign ry_sel = ir_q[2:0];
  assign is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  assign rx_val = r_q[rx_sel];
  assign ry_val = r_q[ry_sel];

  // Single-step ops finish in T1, ALU ops in T3. T2/T3 are only ever reached
  // by ALU ops, so the step alone would suffice there; is_alu keeps the
  // decode robust against an illegal state.
  assign done_raw = ((step_q == T1) && !is_alu) ||
                    ((step_q == T3) &&  is_alu);

  // ---------------------------------------------------------------------------
  // Bus multiplexer: one source or none. The idle value is 0, so the bus never
  // shows a stale operand in T0, on reserved opcodes or on a suppressed mvnz.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so that
    // no path leaves it unassigned and a latch is never inferred.
    bus_val = '0;
    case (step_q)
      T1: begin
        case (op)
          OP_MV:                  bus_val = ry_val;
          OP_MVI:                 bus_val = bus.DIN;
          OP_MVNZ:                if (!zero_q) bus_val = ry_val;
          OP_ADD, OP_SUB, OP_AND: bus_val = rx_val;
          default:                bus_val = '0;
        endcase
      end
      T2:      bus_val = ry_val;
      T3:      bus_val = g_q;
      default: bus_val = '0;
    endcase
  end

  // ALU operates on A and the bus, which carries Ry during T2.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a_q + bus_val;
      OP_SUB:  alu_res = a_q - bus_val;
      OP_AND:  alu_res = a_q & bus_val;
      default: alu_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    step_d = step_q;
    ir_d   = ir_q;
    a_d    = a_q;
    g_d    = g_q;
    zero_d = zero_q;
    r_d    = r_q;

    case (step_q)
      T0: begin
        // Without Run the processor idles in T0 and loads nothing.
        if (bus.Run) begin
          ir_d   = bus.DIN[8:0];
          step_d = T1;
        end
      end

      T1: begin
        case (op)
          OP_MV, OP_MVI:          r_d[rx_sel] = bus_val;
          OP_MVNZ:                if (!zero_q) r_d[rx_sel] = bus_val;
          OP_ADD, OP_SUB, OP_AND: a_d = bus_val;
          default:                ;  // reserved: no register write
        endcase
        step_d = is_alu ? T2 : T0;
      end

      T2: begin
        // Zero tracks G and therefore changes only when G loads.
        g_d    = alu_res;
        zero_d = (alu_res == '0);
        step_d = T3;
      end

      T3: begin
        r_d[rx_sel] = bus_val;
        step_d      = T0;
      end

      default: step_d = T0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!Resetn) begin
      step_q <= T0;
      ir_q   <= '0;
      a_q    <= '0;
      g_q    <= '0;
      zero_q <= 1'b1;
      // NOTE: the register file is small and architecturally visible after
      // reset, so it is cleared explicitly; this keeps it in flops rather than
      // letting it map onto a RAM macro that cannot be reset.
      for (int i = 0; i < 8; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      step_q <= step_d;
      ir_q   <= ir_d;
      a_q    <= a_d;
      g_q    <= g_d;
      zero_q <= zero_d;
      r_q    <= r_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. While Resetn is low the step may still show a mid-instruction
  // value, so Done and the bus are forced low for the whole reset cycle.
  // ---------------------------------------------------------------------------
  assign bus.Done     = done_raw & Resetn;
  assign bus.BusWires = Resetn ? bus_val : '0;
  assign bus.Zero     = zero_q;

endmodule

// File: tb/tb_proc_n.sv
// -----------------------------------------------------------------------------
// tb_proc_n
// Directed bench for proc_n. Two instances: N = 16 for the main sequence and
// N = 24 for the wide wrap-around case. Register contents are observed through
// the bus by issuing mv Rk,Rk, whose T1 bus value is Rk.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_proc_n;

  localparam logic [2:0] MV   = 3'b000;
  localparam logic [2:0] MVI  = 3'b001;
  localparam logic [2:0] ADD  = 3'b010;
  localparam logic [2:0] SUB  = 3'b011;
  localparam logic [2:0] AND_ = 3'b100;
  localparam logic [2:0] MVNZ = 3'b101;
  localparam logic [2:0] RSV6 = 3'b110;

  logic clk = 1'b0;
  logic rstn16;
  logic rstn24;

  always #5 clk = ~clk;

  proc_n_if #(.N(16)) bif16 ();
  proc_n_if #(.N(24)) bif24 ();

  proc_n #(.N(16)) dut16 (.Clock(clk), .Resetn(rstn16), .bus(bif16));
  proc_n #(.N(24)) dut24 (.Clock(clk), .Resetn(rstn24), .bus(bif24));

  int n_checks = 0;
  int n_fail   = 0;

  // Issue one instruction on the 16-bit DUT starting in T0. Returns the number
  // of cycles from the fetch edge until Done (-1 if Done never came) and the
  // bus value seen in the Done cycle.
  task automatic run16(input logic [2:0] op, input logic [2:0] x,
                       input logic [2:0] y, input logic [15:0] imm,
                       output int lat, output logic [15:0] bus_v);
    @(negedge clk);
    bif16.Run = 1'b1;
    bif16.DIN = {7'b0, op, x, y};
    @(negedge clk);
    bif16.Run = 1'b0;  // dropped mid-instruction on purpose; must be ignored
    bif16.DIN = imm;
    #1;
    lat   = -1;
    bus_v = 'x;
    for (int c = 1; c <= 6; c++) begin
      if (bif16.Done === 1'b1) begin
        lat   = c;
        bus_v = bif16.BusWires;
        break;
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic run24(input logic [2:0] op, input logic [2:0] x,
                       input logic [2:0] y, input logic [23:0] imm,
                       output int lat, output logic [23:0] bus_v);
    @(negedge clk);
    bif24.Run = 1'b1;
    bif24.DIN = {15'b0, op, x, y};
    @(negedge clk);
    bif24.Run = 1'b0;
    bif24.DIN = imm;
    #1;
    lat   = -1;
    bus_v = 'x;
    for (int c = 1; c <= 6; c++) begin
      if (bif24.Done === 1'b1) begin
        lat   = c;
        bus_v = bif24.BusWires;
        break;
      end
      @(negedge clk);
      #1;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset;
    rstn16 = 1'b0;
    rstn24 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (bif16.Done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %b expected 0", bif16.Done);
    end
    n_checks++;
    if (bif16.BusWires !== 16'h0000) begin
      n_fail++; $display("FAIL reset_bus: got %h expected 0000", bif16.BusWires);
    end
    n_checks++;
    if (bif16.Zero !== 1'b1) begin
      n_fail++; $display("FAIL reset_zero: got %b expected 1", bif16.Zero);
    end
    n_checks++;
    if (bif24.Zero !== 1'b1) begin
      n_fail++; $display("FAIL reset_zero24: got %b expected 1", bif24.Zero);
    end
    @(negedge clk);
    rstn16 = 1'b1;
    rstn24 = 1'b1;
  endtask

  task automatic test_mvi;
    int lat; logic [15:0] b;
    run16(MVI, 3'd0, 3'd0, 16'h0005, lat, b);
    n_checks++;
    if (lat !== 1) begin
      n_fail++; $display("FAIL mvi_latency: got %0d expected 1", lat);
    end
    n_checks++;
    if (b !== 16'h0005) begin
      n_fail++; $display("FAIL mvi_bus: got %h expected 0005", b);
    end
    run16(MV, 3'd0, 3'd0, 16'h0, lat, b);
    n_checks++;
    if (b !== 16'h0005) begin
      n_fail++; $display("FAIL mvi_r0: got %h expected 0005", b);
    end
  endtask

  task automatic test_add;
    int lat; logic [15:0] b;
    run16(MVI, 3'd1, 3'd0, 16'h0003, lat, b);
    run16(ADD, 3'd0, 3'd1, 16'h0, lat, b);
    n_checks++;
    if (lat !== 3) begin
      n_fail++; $display("FAIL add_latency: got %0d expected 3", lat);
    end
    n_checks++;
    if (b !== 16'h0008) begin
      n_fail++; $display("FAIL add_g_on_bus: got %h expected 0008", b);
    end
    n_checks++;
    if (bif16.Zero !== 1'b0) begin
      n_fail++; $display("FAIL add_zero: got %b expected 0", bif16.Zero);
    end
    run16(MV, 3'd0, 3'd0, 16'h0, lat, b);
    n_checks++;
    if (b !== 16'h0008) begin
      n_fail++; $display("FAIL add_r0: got %h expected 0008", b);
    end
  endtask

  task automatic test_mvnz;
    int lat; logic [15:0] b;
    run16(SUB, 3'd1, 3'd1, 16'h0, lat, b);
    n_checks++;
    if (lat !== 3 || b !== 16'h0000) begin
      n_fail++; $display("FAIL sub_self: got lat %0d bus %h expected lat 3 bus 0000", lat, b);
    end
    n_checks++;
    if (bif16.Zero !== 1'b1) begin
      n_fail++; $display("FAIL sub_zero: got %b expected 1", bif16.Zero);
    end
    run16(MVNZ, 3'd2, 3'd0, 16'h0, lat, b);
    n_checks++;
    if (lat !== 1 || b !== 16'h0000) begin
      n_fail++; $display("FAIL mvnz_suppressed: got lat %0d bus %h expected lat 1 bus 0000", lat, b);
    end
    run16(MV, 3'd2, 3'd2, 16'h0, lat, b);
    n_checks++;
    if (b !== 16'h0000) begin
      n_fail++; $display("FAIL mvnz_r2_kept: got %h expected 0000", b);
    end
    run16(MV, 3'd1, 3'd1, 16'h0, lat, b);
    n_checks++;
    if (b !== 16'h0000) begin
      n_fail++; $display("FAIL sub_r1: got %h expected 0000", b);
    end
    run16(ADD, 3'd0, 3'd0, 16'h0, lat, b);
    n_checks++;
    if (b !== 16'h0010 || bif16.Zero !== 1'b0) begin
      n_fail++; $display("FAIL add_double: got bus %h zero %b expected 0010 0", b, bif16.Zero);
    end
    run16(MVNZ, 3'd2, 3'd0, 16'h0, lat, b);
    n_checks++;
    if (lat !== 1 || b !== 16'h0010) begin
      n_fail++; $display("FAIL mvnz_taken: got lat %0d bus %h expected lat 1 bus 0010", lat, b);
    end
    run16(MV, 3'd2, 3'd2, 16'h0, lat, b);
    n_checks++;
    if (b !== 16'h0010) begin
      n_fail++; $display("FAIL mvnz_r2: got %h expected 0010", b);
    end
  endtask

  task automatic test_wrap_and;
    int lat; logic [15:0] b;
    run16(MVI, 3'd3, 3'd0, 16'hFFFF, lat, b);
    run16(MVI, 3'd4, 3'd0, 16'h0001, lat, b);
    run16(ADD, 3'd3, 3'd4, 16'h0, lat, b);
    n_checks++;
    if (b !== 16'h0000 || bif16.Zero !== 1'b1) begin
      n_fail++; $display("FAIL add_wrap: got bus %h zero %b expected 0000 1", b, bif16.Zero);
    end
    run16(MV, 3'd3, 3'd3, 16'h0, lat, b);
    n_checks++;
    if (b !== 16'h0000) begin
      n_fail++; $display("FAIL add_wrap_r3: got %h expected 0000", b);
    end
    run16(MVI, 3'd5, 3'd0, 16'h0F0F, lat, b);
    run16(AND_, 3'd5, 3'd4, 16'h0, lat, b);
    n_checks++;
    if (lat !== 3 || b !== 16'h0001 || bif16.Zero !== 1'b0) begin
      n_fail++; $display("FAIL and_op: got lat %0d bus %h zero %b expected 3 0001 0", lat, b, bif16.Zero);
    end
    run16(MV, 3'd5, 3'd5, 16'h0, lat, b);
    n_checks++;
    if (b !== 16'h0001) begin
      n_fail++; $display("FAIL and_r5: got %h expected 0001", b);
    end
  endtask

  task automatic test_idle_reserved;
    int lat; logic [15:0] b;
    bif16.Run = 1'b0;
    bif16.DIN = {7'b0, MVI, 3'd0, 3'd0};  // would be a fetch if Run were high
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (bif16.Done !== 1'b0 || bif16.BusWires !== 16'h0000) begin
        n_fail++; $display("FAIL idle_cycle%0d: got done %b bus %h expected 0 0000", c, bif16.Done, bif16.BusWires);
      end
    end
    run16(RSV6, 3'd0, 3'd1, 16'hABCD, lat, b);
    n_checks++;
    if (lat !== 1 || b !== 16'h0000) begin
      n_fail++; $display("FAIL reserved: got lat %0d bus %h expected lat 1 bus 0000", lat, b);
    end
    n_checks++;
    if (bif16.Zero !== 1'b0) begin
      n_fail++; $display("FAIL reserved_zero: got %b expected 0", bif16.Zero);
    end
    run16(MV, 3'd0, 3'd0, 16'h0, lat, b);
    n_checks++;
    if (b !== 16'h0010) begin
      n_fail++; $display("FAIL reserved_r0: got %h expected 0010", b);
    end
    run16(MV, 3'd1, 3'd1, 16'h0, lat, b);
    n_checks++;
    if (b !== 16'h0000) begin
      n_fail++; $display("FAIL reserved_r1: got %h expected 0000", b);
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic [15:0] b;
    run16(MVI, 3'd6, 3'd0, 16'h1234, lat, b);
    run16(MV, 3'd7, 3'd6, 16'h0, lat, b);
    n_checks++;
    if (lat !== 1 || b !== 16'h1234) begin
      n_fail++; $display("FAIL b2b_mv: got lat %0d bus %h expected lat 1 bus 1234", lat, b);
    end
    run16(MV, 3'd7, 3'd7, 16'h0, lat, b);
    n_checks++;
    if (b !== 16'h1234) begin
      n_fail++; $display("FAIL b2b_r7: got %h expected 1234", b);
    end
  endtask

  task automatic test_reset_mid;
    int lat; logic [15:0] b;
    @(negedge clk);                          // T0: fetch add R0,R6
    bif16.Run = 1'b1;
    bif16.DIN = {7'b0, ADD, 3'd0, 3'd6};
    @(negedge clk);                          // T1
    bif16.Run = 1'b0;
    @(negedge clk);                          // T2, would drive R6 = 1234
    rstn16 = 1'b0;
    #1;
    n_checks++;
    if (bif16.Done !== 1'b0 || bif16.BusWires !== 16'h0000) begin
      n_fail++; $display("FAIL reset_mid_during: got done %b bus %h expected 0 0000", bif16.Done, bif16.BusWires);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bif16.Done !== 1'b0 || bif16.BusWires !== 16'h0000 || bif16.Zero !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_after: got done %b bus %h zero %b expected 0 0000 1", bif16.Done, bif16.BusWires, bif16.Zero);
    end
    rstn16 = 1'b1;
    run16(MV, 3'd0, 3'd0, 16'h0, lat, b);
    n_checks++;
    if (lat !== 1 || b !== 16'h0000) begin
      n_fail++; $display("FAIL reset_mid_r0: got lat %0d bus %h expected lat 1 bus 0000", lat, b);
    end
    run16(MV, 3'd6, 3'd6, 16'h0, lat, b);
    n_checks++;
    if (b !== 16'h0000) begin
      n_fail++; $display("FAIL reset_mid_r6: got %h expected 0000", b);
    end
    run16(MV, 3'd7, 3'd7, 16'h0, lat, b);
    n_checks++;
    if (b !== 16'h0000) begin
      n_fail++; $display("FAIL reset_mid_r7: got %h expected 0000", b);
    end
  endtask

  task automatic test_wide;
    int lat; logic [23:0] b;
    run24(MVI, 3'd0, 3'd0, 24'hFFFFFF, lat, b);
    n_checks++;
    if (lat !== 1 || b !== 24'hFFFFFF) begin
      n_fail++; $display("FAIL n24_mvi: got lat %0d bus %h expected lat 1 bus ffffff", lat, b);
    end
    run24(MVI, 3'd1, 3'd0, 24'h000001, lat, b);
    run24(ADD, 3'd0, 3'd1, 24'h0, lat, b);
    n_checks++;
    if (lat !== 3 || b !== 24'h000000 || bif24.Zero !== 1'b1) begin
      n_fail++; $display("FAIL n24_add_wrap: got lat %0d bus %h zero %b expected 3 000000 1", lat, b, bif24.Zero);
    end
    run24(MV, 3'd0, 3'd0, 24'h0, lat, b);
    n_checks++;
    if (b !== 24'h000000) begin
      n_fail++; $display("FAIL n24_r0: got %h expected 000000", b);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    bif16.Run = 1'b0;
    bif16.DIN = '0;
    bif24.Run = 1'b0;
    bif24.DIN = '0;
    rstn16    = 1'b0;
    rstn24    = 1'b0;

    test_reset();
    test_mvi();
    test_add();
    test_mvnz();
    test_wrap_and();
    test_idle_reserved();
    test_back_to_back();
    test_reset_mid();
    test_wide();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_n.md
# proc_n

Parametrised successor to the team's 8-register simple processor. It executes a 9-bit instruction (3-bit opcode, 3-bit Rx, 3-bit Ry) over a one-hot-driven shared bus of configurable data width. Compared with the previous generation it adds Run-gated fetch, a registered zero flag, AND and conditional-move instructions, a defined idle bus value, and full synchronous reset of all state. It sits between an instruction/data source (ROM or switches driving DIN) and display or memory logic observing BusWires and Done.

## Interface
- N, 16, data/bus width; must be ≥ 9 (IR is taken from DIN[8:0])
- Clock  in  1  rising-edge clock
- Resetn  in  1  synchronous, active-low reset (one clock, one reset domain)
- Run  in  1  start request; sampled in step T0
- DIN  in  N  instruction word in T0; immediate operand in T1 for mvi
- Done  out  1  high in the final step of every instruction
- BusWires  out  N  shared bus value
- Zero  out  1  registered flag, 1 when G == 0

## Operation
- Registers:
  - R0..R7, A and G are N bits.
  - IR is 9 bits. IR[8:6] is the opcode I, IR[5:3] is X, IR[2:0] is Y.
  - Zero is 1 bit.
- Step counter T0..T3 (2 bits):
  - Clears to T0 on the edge after Done.
  - Stays in T0 while Run = 0.
  - Otherwise increments.
- T0, all opcodes: if Run = 1, IR <= DIN[8:0] and go to T1. If Run = 0, hold and load nothing.
- Opcodes (actions listed T1 / T2 / T3):
  - 000 mv: Rx <= Ry; Done in T1.
  - 001 mvi: Rx <= DIN; Done in T1.
  - 010 add: T1 A <= Rx; T2 G <= A + Ry; T3 Rx <= G, Done.
  - 011 sub: as add, but G <= A − Ry.
  - 100 and: as add, but G <= A & Ry.
  - 101 mvnz: if Zero = 0 then Rx <= Ry, else no write; Done in T1 either way.
  - 110, 111 reserved: no register write; Done in T1.
- Arithmetic is modulo 2^N. Carry and borrow are discarded.
- Zero <= (ALU result == 0). It updates only when G loads (T2 of add/sub/and) and holds otherwise.
- Bus sources (exactly one, or none):
  - DIN in mvi T1.
  - G in T3.
  - Ry in mv T1, in T2, and in mvnz T1 only when Zero = 0.
  - Rx in T1 of add/sub/and.
  - When no source is selected (T0, reserved opcodes, mvnz with Zero = 1), BusWires = 0. It never holds a stale value.
- Rx = Ry is legal in every opcode:
  - add R3,R3 doubles R3.
  - sub R3,R3 gives 0 and sets Zero.
  - mv R3,R3 is a no-op write.

## Timing
- Reset: the synchronous edge with Resetn = 0 sets:
  - step = T0
  - IR = 0, A = 0, G = 0, R0..R7 = 0, Zero = 1
- During reset Done = 0 and BusWires = 0.
- Reset overrides a mid-instruction step (for example asserting in T2 of add): no register update occurs on that edge.
- Latency from the Run-sampled T0 edge to Done: 1 cycle for mv/mvi/mvnz/reserved, 3 cycles for add/sub/and.
- Done is combinational from step and I. It is high for exactly one cycle. The register write happens on the same edge that returns the step to T0.
- Throughput: back-to-back instructions are allowed. T0 immediately follows Done, and a new IR loads there if Run = 1.
- Run is ignored outside T0. Dropping Run mid-instruction does not abort.
- Outputs are glitch-tolerant combinational: BusWires and Done are valid before the next rising edge.

## Test plan
- Reset, then mvi R0,#0x0005 with Run held at 1 → Done in T1; R0 = 0x0005; BusWires = 0x0005 in that cycle.
- mvi R1,#0x0003; add R0,R1 → Done 3 cycles after fetch; R0 = 0x0008; Zero = 0.
- sub R1,R1, then mvnz R2,R0 → R1 = 0, Zero = 1, R2 unchanged (0). Then add R0,R0 (R0 = 0x0010, Zero = 0) and mvnz R2,R0 → R2 = 0x0010.
- Wrap and AND: mvi R3,#0xFFFF; mvi R4,#0x0001; add R3,R4 → R3 = 0x0000, Zero = 1. Then mvi R5,#0x0F0F; and R5,R4 → R5 = 0x0001.
- Run = 0 for 5 cycles → step stays T0, no Done, BusWires = 0. Reserved opcode 110 → Done in T1, no register changes.
- Resetn = 0 during T2 of add → next cycle: all registers 0, step T0, Done = 0. Re-run with N = 24: add 0xFFFFFF + 1 → 0x000000, Zero = 1.
